inst_enc: RTL and testbench

Instruction encoder: packs decoded RV32 fields (type, opcode, registers, funct, full 32-bit immediate) into a 32-bit instruction word. It is the inverse of the core's immediate generator.
Immediates are range-checked per format. Results are queued in a small output FIFO with valid/ready on both sides.
Used by the self-test program loader and by the bench to synthesize instruction streams for the NPC fetch path.

---
 rtl/inst_enc_if.sv | 33 +++
 rtl/inst_enc.sv | 121 ++++++++++++
 tb/tb_inst_enc.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_enc_if.sv
// rtl/inst_enc_if.sv - request/response handshake bundle for the RV32 instruction encoder
//   in_valid/in_ready  : request handshake, fields in_type..in_imm sampled on accept
//   out_valid/out_ready: response handshake, out_inst/out_err show the FIFO head
interface inst_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  // encoder side
  modport slave (
    input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );

  // requester / consumer side
  modport master (
    output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/inst_enc.sv
// rtl/inst_enc.sv - RV32 instruction encoder with range check and output FIFO
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : inst_enc_if.slave request/response handshake
//   enc_cnt    : accepted requests (wraps)
//   err_cnt    : accepted requests that failed the immediate range check (wraps)
module inst_enc #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_enc_if.slave        bus,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] T_I = 3'b000;
  localparam logic [2:0] T_U = 3'b001;
  localparam logic [2:0] T_S = 3'b010;
  localparam logic [2:0] T_J = 3'b011;
  localparam logic [2:0] T_R = 3'b100;
  localparam logic [2:0] T_B = 3'b101;
  localparam logic [2:0] T_N = 3'b111;

  logic [31:0]      r_mem_inst [DEPTH];
  logic             r_mem_err  [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [31:0] w_word;
  logic        w_err;
  logic [31:0] w_enc;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_fits_12;
  logic        w_fits_13;
  logic        w_fits_21;

  // A signed value fits an n-bit field when every bit from n-1 upward matches.
  assign w_fits_12 = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
  assign w_fits_13 = (&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12]);
  assign w_fits_21 = (&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20]);

  always_comb begin
    w_word = 32'h0;
    w_err  = 1'b0;
    unique case (bus.in_type)
      T_R: w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     bus.in_rd, bus.in_opcode};
      T_I: begin
        w_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        w_err  = !w_fits_12;
      end
      T_S: begin
        w_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                  bus.in_imm[4:0], bus.in_opcode};
        w_err  = !w_fits_12;
      end
      T_B: begin
        w_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                  bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
        w_err  = !w_fits_13 | bus.in_imm[0];
      end
      T_U: begin
        w_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
        w_err  = |bus.in_imm[11:0];
      end
      T_J: begin
        w_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                  bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
        w_err  = !w_fits_21 | bus.in_imm[0];
      end
      T_N:     w_word = 32'h0;
      default: w_err  = 1'b1;
    endcase
  end

  // Failed encodings are queued as a zero word so the consumer never sees partial fields.
  assign w_enc = w_err ? 32'h0 : w_word;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = bus.in_valid & !w_full;
  assign w_pop   = bus.out_ready & !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= 32'h0;
        r_mem_err[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_inst[r_wr_ptr[AW-1:0]] <= w_enc;
        r_mem_err[r_wr_ptr[AW-1:0]]  <= w_err;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_enc_cnt <= r_enc_cnt + 1'b1;
        if (w_err) r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_inst  = w_empty ? 32'h0 : r_mem_inst[r_rd_ptr[AW-1:0]];
  assign bus.out_err   = w_empty ? 1'b0  : r_mem_err[r_rd_ptr[AW-1:0]];
  assign enc_cnt       = r_enc_cnt;
  assign err_cnt       = r_err_cnt;
endmodule

// File: tb/tb_inst_enc.sv
// tb/tb_inst_enc.sv - self-checking bench for inst_enc
module tb_inst_enc;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;

  inst_enc_if bus ();

  inst_enc #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  int n_checks = 0;
  int n_errs   = 0;

  vec_t        tbl [11];
  logic [31:0] q_inst [$];
  logic        q_err  [$];
  logic [CNT_W-1:0] m_enc;
  logic [CNT_W-1:0] m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: numeric ranges and shifted/masked fields.
  function automatic void model(input vec_t v, output logic [31:0] w, output logic e);
    int          si;
    logic [31:0] imm, op, rd, rs1, rs2, f3, f7;
    imm = v.imm; si = $signed(v.imm);
    op = 32'(v.op); rd = 32'(v.rd); rs1 = 32'(v.rs1);
    rs2 = 32'(v.rs2); f3 = 32'(v.f3); f7 = 32'(v.f7);
    e = 1'b0; w = 32'h0;
    case (v.t)
      3'd4: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd0: begin
        e = (si < -2048) || (si > 2047);
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd2: begin
        e = (si < -2048) || (si > 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((imm & 32'h1F) << 7) | op;
      end
      3'd5: begin
        e = (si < -4096) || (si > 4095) || (imm % 2 != 0);
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
            | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
            | (((imm >> 11) & 1) << 7) | op;
      end
      3'd1: begin
        e = (imm % 4096) != 0;
        w = (imm & 32'hFFFFF000) | (rd << 7) | op;
      end
      3'd3: begin
        e = (si < -(1 << 20)) || (si > (1 << 20) - 1) || (imm % 2 != 0);
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      end
      3'd7: w = 32'h0;
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0;
  endfunction

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid  = valid;
    bus.in_type   = v.t;
    bus.in_opcode = v.op;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct3 = v.f3;
    bus.in_funct7 = v.f7;
    bus.in_imm    = v.imm;
  endtask

  function automatic vec_t mk(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.t = t; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    int   m;
    v.t = 3'($urandom_range(0, 7)); v.op = 7'($urandom); v.rd = 5'($urandom);
    v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.f3 = 3'($urandom); v.f7 = 7'($urandom);
    m = $urandom_range(0, 3);
    case (m)
      0: v.imm = $urandom;
      1: v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: v.imm = $urandom & 32'hFFFFF000;
      default: v.imm = {{11{v.rd[0]}}, 21'($urandom)};
    endcase
    v.exp_inst = 32'h0; v.exp_err = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t        v, va, vb, vc;
    logic [31:0] wa, wb, wc, w;
    logic        ea, eb, ec, e;
    int          exp_enc, exp_errc, base, sz;

    tbl[0]  = mk(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    tbl[1]  = mk(3'd1, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    tbl[2]  = mk(3'd5, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    tbl[3]  = mk(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
    tbl[4]  = mk(3'd4, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0);
    tbl[5]  = mk(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h00000008, 32'h0020A423, 1'b0);
    tbl[6]  = mk(3'd7, 7'b1111111, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h12345678, 32'h00000000, 1'b0);
    tbl[7]  = mk(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h00000000, 1'b1);
    tbl[8]  = mk(3'd5, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000003, 32'h00000000, 1'b1);
    tbl[9]  = mk(3'd1, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h00000000, 1'b1);
    tbl[10] = mk(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000000, 32'h00000000, 1'b1);

    v = tbl[0];
    drive(v, 1'b0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;

    // Directed table: each request pops the cycle after it is accepted.
    exp_enc = 0; exp_errc = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      drive(tbl[i], 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      exp_enc++;
      if (tbl[i].exp_err) exp_errc++;
      @(negedge clk);
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("tbl%0d_out_inst", i), bus.out_inst, tbl[i].exp_inst);
      chk($sformatf("tbl%0d_out_err", i), 32'(bus.out_err), 32'(tbl[i].exp_err));
      model(tbl[i], w, e);
      chk($sformatf("tbl%0d_model_inst", i), bus.out_inst, w);
    end
    @(negedge clk);
    chk("tbl_empty", 32'(bus.out_valid), 32'd0);
    chk("tbl_enc_cnt", 32'(enc_cnt), 32'(exp_enc));
    chk("tbl_err_cnt", 32'(err_cnt), 32'(exp_errc));

    // Backpressure: two accepts fill the FIFO, third waits for the first pop.
    base = exp_enc;
    va = tbl[0]; vb = tbl[7]; vc = tbl[2];
    model(va, wa, ea); model(vb, wb, eb); model(vc, wc, ec);
    bus.out_ready = 1'b0;
    drive(va, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_1", 32'(bus.in_ready), 32'd1);
    chk("bp_head_a1", bus.out_inst, wa);
    drive(vb, 1'b1);
    @(negedge clk);
    chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_head_a2", bus.out_inst, wa);
    drive(vc, 1'b1);
    @(negedge clk);
    chk("bp_ready_held", 32'(bus.in_ready), 32'd0);
    chk("bp_head_a3", bus.out_inst, wa);
    chk("bp_err_a3", 32'(bus.out_err), 32'(ea));
    chk("bp_enc_held", 32'(enc_cnt), 32'(base + 2));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
    chk("bp_head_b", bus.out_inst, wb);
    chk("bp_err_b", 32'(bus.out_err), 32'(eb));
    chk("bp_enc_no_bypass", 32'(enc_cnt), 32'(base + 2));
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_head_c", bus.out_inst, wc);
    chk("bp_err_c", 32'(bus.out_err), 32'(ec));
    chk("bp_enc_c", 32'(enc_cnt), 32'(base + 3));
    @(negedge clk);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Reset with two entries queued.
    bus.out_ready = 1'b0;
    drive(tbl[1], 1'b1);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_full", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_enc", 32'(enc_cnt), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", 32'(bus.out_valid), 32'd0);
    drive(tbl[0], 1'b1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_inst", bus.out_inst, 32'hFFF00093);
    chk("post_rst_enc", 32'(enc_cnt), 32'd1);
    @(negedge clk);

    // Random traffic against a queue scoreboard.
    m_enc = 16'd1; m_err = 16'd0;
    q_inst.delete(); q_err.delete();
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(q_inst.size() != 0));
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(q_inst.size() < DEPTH));
      if (q_inst.size() != 0) begin
        chk("rnd_out_inst", bus.out_inst, q_inst[0]);
        chk("rnd_out_err", 32'(bus.out_err), 32'(q_err[0]));
      end
      chk("rnd_enc_cnt", 32'(enc_cnt), 32'(m_enc));
      chk("rnd_err_cnt", 32'(err_cnt), 32'(m_err));
      v = rnd_vec();
      drive(v, 1'($urandom_range(0, 2) != 0));
      bus.out_ready = 1'($urandom_range(0, 2) == 0);
      sz = q_inst.size();
      if (bus.in_valid && sz < DEPTH) begin
        model(v, w, e);
        q_inst.push_back(w);
        q_err.push_back(e);
        m_enc = m_enc + 1'b1;
        if (e) m_err = m_err + 1'b1;
      end
      if (bus.out_ready && sz > 0) begin
        void'(q_inst.pop_front());
        void'(q_err.pop_front());
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
